// File: rtl/fft_out_reorder.sv
// fft_out_reorder
//   Puts FFT output samples back into natural order. A 32-point complex frame
//   arrives as two 16-lane beats and is written into one bank of a ping-pong
//   buffer. Once a bank is full, one 16-lane index vector is popped from the
//   bit-reversal index FIFO per output beat. Each output lane is gathered from
//   the buffered frame at the index it was given.
//
//   Handshakes:
//     din   : valid/ready. A beat transfers on a posedge where din_valid &&
//             din_ready. din_ready depends only on registered state.
//     idx   : idx_req pops one vector per asserted cycle. idx_in carries the
//             vector on the following cycle.
//     dout  : valid only, with no backpressure. dout_last marks beat 1 of a
//             frame.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   din_valid/din_ready  input beat handshake
//   din_re/din_im        16 lanes of DW-bit real/imag input samples
//   idx_empty            index FIFO empty flag
//   idx_req              index FIFO pop (FIFO dout_en)
//   idx_in               16 lanes of IDX_W-bit gather indices
//   dout_valid/dout_last output beat strobe and second-beat marker
//   dout_re/dout_im      16 lanes of reordered real/imag samples
module fft_out_reorder #(
  parameter int N_PTS = 32,
  parameter int LANES = 16,
  parameter int IDX_W = 5,
  parameter int DW    = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [DW-1:0]    din_re [0:LANES-1],
  input  logic [DW-1:0]    din_im [0:LANES-1],
  input  logic             idx_empty,
  output logic             idx_req,
  input  logic [IDX_W-1:0] idx_in [0:LANES-1],
  output logic             dout_valid,
  output logic             dout_last,
  output logic [DW-1:0]    dout_re [0:LANES-1],
  output logic [DW-1:0]    dout_im [0:LANES-1]
);

  // Lane-offset bits inside one beat. The top index bit selects the beat half.
  localparam int LW = IDX_W - 1;

  typedef enum logic {R_IDLE = 1'b0, R_B1 = 1'b1} rd_state_t;

  rd_state_t  rd_state;
  logic [1:0] bank_full;
  logic [1:0] bank_full_nxt;
  logic       wr_bank;
  logic       wr_beat;
  logic       rd_bank;
  logic       idx_pend;
  logic       pend_bank;
  logic       pend_beat;
  logic       wr_fire;

  // Sample storage is not reset. A bank only becomes readable after both of
  // its beats have been written.
  logic [DW-1:0] mem_re [0:1][0:N_PTS-1];
  logic [DW-1:0] mem_im [0:1][0:N_PTS-1];

  assign din_ready = !bank_full[wr_bank];
  assign wr_fire   = din_valid && din_ready;

  // Beat 0 of a frame waits for a full bank. Beat 1 only needs an index vector,
  // so an empty FIFO simply parks the FSM in R_B1.
  assign idx_req = (rd_state == R_B1) ? !idx_empty
                                      : (bank_full[rd_bank] && !idx_empty);

  // Freeing and filling target different banks whenever both occur on the
  // same edge: the write bank is only writable while it is not full.
  always_comb begin
    bank_full_nxt = bank_full;
    if (idx_pend && pend_beat) bank_full_nxt[pend_bank] = 1'b0;
    if (wr_fire && wr_beat)    bank_full_nxt[wr_bank]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < LANES; i++) begin
        mem_re[wr_bank][{wr_beat, LW'(i)}] <= din_re[i];
        mem_im[wr_bank][{wr_beat, LW'(i)}] <= din_im[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_state   <= R_IDLE;
      bank_full  <= '0;
      wr_bank    <= 1'b0;
      wr_beat    <= 1'b0;
      rd_bank    <= 1'b0;
      idx_pend   <= 1'b0;
      pend_bank  <= 1'b0;
      pend_beat  <= 1'b0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        dout_re[i] <= '0;
        dout_im[i] <= '0;
      end
    end else begin
      bank_full <= bank_full_nxt;
      idx_pend  <= idx_req;

      if (wr_fire) begin
        wr_beat <= !wr_beat;
        if (wr_beat) wr_bank <= !wr_bank;
      end

      // pend_* describes the vector that arrives on idx_in next cycle.
      case (rd_state)
        R_IDLE: begin
          if (idx_req) begin
            rd_state  <= R_B1;
            pend_beat <= 1'b0;
            pend_bank <= rd_bank;
          end
        end
        R_B1: begin
          if (idx_req) begin
            rd_state  <= R_IDLE;
            pend_beat <= 1'b1;
            pend_bank <= rd_bank;
            rd_bank   <= !rd_bank;
          end
        end
        default: rd_state <= R_IDLE;
      endcase

      // Gather. The output data registers hold their value between beats.
      if (idx_pend) begin
        for (int i = 0; i < LANES; i++) begin
          dout_re[i] <= mem_re[pend_bank][idx_in[i]];
          dout_im[i] <= mem_im[pend_bank][idx_in[i]];
        end
        dout_valid <= 1'b1;
        dout_last  <= pend_beat;
      end else begin
        dout_valid <= 1'b0;
        dout_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
module tb_fft_out_reorder;

  localparam int LANES = 16;
  localparam int IDX_W = 5;
  localparam int DW    = 16;
  localparam int BW    = 2 * LANES * DW + 1;  // {last, im lanes, re lanes}

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic             din_valid;
  logic             din_ready;
  logic [DW-1:0]    din_re [0:LANES-1];
  logic [DW-1:0]    din_im [0:LANES-1];
  logic             idx_empty;
  logic             idx_req;
  logic [IDX_W-1:0] idx_in [0:LANES-1];
  logic             dout_valid;
  logic             dout_last;
  logic [DW-1:0]    dout_re [0:LANES-1];
  logic [DW-1:0]    dout_im [0:LANES-1];

  fft_out_reorder dut (
    .clk        (clk),
    .rstn       (rstn),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_re     (din_re),
    .din_im     (din_im),
    .idx_empty  (idx_empty),
    .idx_req    (idx_req),
    .idx_in     (idx_in),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .dout_re    (dout_re),
    .dout_im    (dout_im)
  );

  // ---------------- index FIFO model ----------------
  logic [LANES*IDX_W-1:0] fifo_mem [0:63];
  int                     fifo_wr = 0;
  int                     fifo_rd = 0;
  logic [LANES*IDX_W-1:0] idx_word = '0;

  assign idx_empty = (fifo_wr == fifo_rd);

  always_comb begin
    for (int i = 0; i < LANES; i++) idx_in[i] = idx_word[i*IDX_W +: IDX_W];
  end

  // ---------------- scoreboard state ----------------
  logic [BW-1:0] exp_q [$];
  int            checks     = 0;
  int            errors     = 0;
  int            beats_seen = 0;
  int            last_cyc   = 0;
  int            acc_cyc    = 0;
  int            cyc        = 0;
  logic          req_now;
  logic          req_d      = 1'b0;
  logic [BW-1:0] got_beat;
  logic [BW-1:0] exp_beat;

  // Monitor: pops the FIFO model, checks the two-cycle request-to-valid
  // latency and compares every output beat against the expected queue.
  always begin
    @(posedge clk);
    cyc++;
    req_now = idx_req;
    if (rstn && idx_req) begin
      checks++;
      if (fifo_wr == fifo_rd) begin
        errors++;
        $display("FAIL idx_req_on_empty cyc %0d: got idx_req=1 required 0", cyc);
      end else begin
        idx_word <= fifo_mem[fifo_rd % 64];
        fifo_rd  <= fifo_rd + 1;
      end
    end
    #1;
    if (!rstn) begin
      req_d = 1'b0;
    end else begin
      checks++;
      if (dout_valid !== req_d) begin
        errors++;
        $display("FAIL valid_latency cyc %0d: got dout_valid=%0b required %0b", cyc, dout_valid, req_d);
      end
      if (dout_valid) begin
        beats_seen++;
        if (dout_last) last_cyc = cyc;
        for (int i = 0; i < LANES; i++) begin
          got_beat[i*DW +: DW]            = dout_re[i];
          got_beat[LANES*DW + i*DW +: DW] = dout_im[i];
        end
        got_beat[BW-1] = dout_last;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat cyc %0d: got a beat required none", cyc);
        end else begin
          exp_beat = exp_q.pop_front();
          if (got_beat !== exp_beat) begin
            errors++;
            $display("FAIL beat_data cyc %0d: got %h required %h", cyc, got_beat, exp_beat);
          end
        end
      end
      req_d = req_now;
    end
  end

  // ---------------- helpers / driver tasks ----------------
  function automatic logic [IDX_W-1:0] idx_of(input int mode, input int beat, input int lane);
    logic [IDX_W-1:0] j;
    logic [IDX_W-1:0] r;
    j = IDX_W'(beat * LANES + lane);
    r = j;
    case (mode)
      0:       for (int b = 0; b < IDX_W; b++) r[b] = j[IDX_W-1-b];  // bit reverse
      1:       r = 5'd7;                                          // all duplicates
      2:       r = j;                                             // identity
      3:       r = ~j;                                            // 31 - j
      default: r = IDX_W'((1 - beat) * LANES + lane);             // swap halves
    endcase
    return r;
  endfunction

  // Push one index vector into the FIFO model and its expected output beat.
  task automatic push_vec(input logic [DW-1:0] base, input int mode, input int beat);
    logic [LANES*IDX_W-1:0] w;
    logic [BW-1:0]          e;
    logic [IDX_W-1:0]       ix;
    for (int lane = 0; lane < LANES; lane++) begin
      ix = idx_of(mode, beat, lane);
      w[lane*IDX_W +: IDX_W]        = ix;
      e[lane*DW +: DW]              = DW'(int'(base) + int'(ix));
      e[LANES*DW + lane*DW +: DW]   = DW'(int'(base) + int'(ix) + 100);
    end
    e[BW-1] = (beat == 1);
    fifo_mem[fifo_wr % 64] = w;
    fifo_wr++;
    exp_q.push_back(e);
  endtask

  // Sample j of a frame: re = base + j, im = base + j + 100.
  task automatic send_beat(input logic [DW-1:0] base, input int beat);
    int guard;
    @(negedge clk);
    din_valid = 1'b1;
    for (int lane = 0; lane < LANES; lane++) begin
      din_re[lane] = DW'(int'(base) + beat * LANES + lane);
      din_im[lane] = DW'(int'(base) + beat * LANES + lane + 100);
    end
    guard = 0;
    while (!din_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (!din_ready) begin
      errors++;
      $display("FAIL din_ready_timeout: got din_ready=0 required 1");
      din_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] base);
    send_beat(base, 0);
    send_beat(base, 1);
  endtask

  task automatic idle();
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic wait_out(input string name);
    int g;
    g = 0;
    do begin
      @(posedge clk);
      #1;
      g++;
    end while (!dout_valid && g < 50);
    chk({name, "_valid"}, int'(dout_valid), 1);
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 400) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [DW-1:0] base;
    int            mode;
    int            e0l0;   // beat0 lane0 re
    int            e0l1;   // beat0 lane1 re
    int            e1l0;   // beat1 lane0 re
    int            e1l15;  // beat1 lane15 re
  } vec_t;

  vec_t tbl [6];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test required finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int beats0;
    din_valid = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      din_re[i] = '0;
      din_im[i] = '0;
    end

    tbl[0] = '{16'd0,     0, 0,       16,      1,       31};
    tbl[1] = '{16'd200,   1, 207,     207,     207,     207};
    tbl[2] = '{16'd400,   2, 400,     401,     416,     431};
    tbl[3] = '{16'd1000,  3, 1031,    1030,    1015,    1000};
    tbl[4] = '{16'd3000,  4, 3016,    3017,    3000,    3015};
    tbl[5] = '{16'hFFC0,  0, 'hFFC0,  'hFFD0,  'hFFC1,  'hFFDF};

    // Reset state.
    #12;
    chk("rst_dout_valid", int'(dout_valid), 0);
    chk("rst_dout_last",  int'(dout_last), 0);
    chk("rst_din_ready",  int'(din_ready), 1);
    chk("rst_idx_req",    int'(idx_req), 0);
    chk("rst_dout_re0",   int'(dout_re[0]), 0);
    chk("rst_dout_im15",  int'(dout_im[15]), 0);
    @(negedge clk);
    rstn = 1'b1;

    // Single frames, one per table record.
    for (int r = 0; r < 6; r++) begin
      push_vec(tbl[r].base, tbl[r].mode, 0);
      push_vec(tbl[r].base, tbl[r].mode, 1);
      send_frame(tbl[r].base);
      idle();
      wait_out("tbl_b0");
      chk("tbl_b0_last",   int'(dout_last), 0);
      chk("tbl_b0_re0",    int'(dout_re[0]), tbl[r].e0l0);
      chk("tbl_b0_re1",    int'(dout_re[1]), tbl[r].e0l1);
      chk("tbl_b0_im0",    int'(dout_im[0]), (tbl[r].e0l0 + 100) % 65536);
      @(posedge clk);
      #1;
      chk("tbl_b1_valid",  int'(dout_valid), 1);
      chk("tbl_b1_last",   int'(dout_last), 1);
      chk("tbl_b1_re0",    int'(dout_re[0]), tbl[r].e1l0);
      chk("tbl_b1_re15",   int'(dout_re[15]), tbl[r].e1l15);
      @(posedge clk);
      #1;
      chk("tbl_idle_valid", int'(dout_valid), 0);
      chk("tbl_hold_re0",   int'(dout_re[0]), tbl[r].e1l0);
    end

    // Index starvation between beat0 and beat1.
    push_vec(16'd4000, 0, 0);
    send_frame(16'd4000);
    idle();
    wait_out("starve_b0");
    chk("starve_b0_last", int'(dout_last), 0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("starve_req_low", int'(idx_req), 0);
    end
    @(negedge clk);
    push_vec(16'd4000, 0, 1);
    #1;
    chk("starve_req_high", int'(idx_req), 1);
    @(posedge clk);
    #1;
    chk("starve_lat1_valid", int'(dout_valid), 0);
    @(posedge clk);
    #1;
    chk("starve_lat2_valid", int'(dout_valid), 1);
    chk("starve_lat2_last",  int'(dout_last), 1);
    chk("starve_b1_re0",     int'(dout_re[0]), 4001);

    // Backpressure: both banks full, third frame held at the input.
    send_frame(16'd5000);
    send_frame(16'd5100);
    chk("bp_ready_low", int'(din_ready), 0);
    fork
      begin
        send_beat(16'd5200, 0);
        acc_cyc = cyc;
      end
      begin : bp_reader
        int g2;
        repeat (3) @(negedge clk);
        chk("bp_ready_held", int'(din_ready), 0);
        push_vec(16'd5000, 2, 0);
        push_vec(16'd5000, 2, 1);
        g2 = 0;
        do begin
          @(posedge clk);
          #1;
          g2++;
        end while (!(dout_valid && dout_last) && g2 < 50);
        chk("bp_f1_last", int'(dout_last), 1);
      end
    join
    chk("bp_accept_cycle", acc_cyc, last_cyc + 1);
    send_beat(16'd5200, 1);
    idle();
    push_vec(16'd5100, 4, 0);
    push_vec(16'd5100, 4, 1);
    push_vec(16'd5200, 0, 0);
    push_vec(16'd5200, 0, 1);
    drain("bp");

    // Continuous streaming of 8 frames with the FIFO preloaded.
    beats0 = beats_seen;
    for (int k = 0; k < 8; k++) begin
      push_vec(DW'(6000 + k * 40), k % 5, 0);
      push_vec(DW'(6000 + k * 40), k % 5, 1);
    end
    for (int k = 0; k < 8; k++) send_frame(DW'(6000 + k * 40));
    idle();
    drain("stream");
    chk("stream_beat_count", beats_seen - beats0, 16);

    // Reset in the middle of an output frame.
    push_vec(16'd7000, 0, 0);
    push_vec(16'd7000, 0, 1);
    send_frame(16'd7000);
    idle();
    wait_out("rst_b0");
    chk("rst_b0_re1", int'(dout_re[1]), 7016);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_dout_valid", int'(dout_valid), 0);
    chk("midrst_dout_last",  int'(dout_last), 0);
    chk("midrst_idx_req",    int'(idx_req), 0);
    chk("midrst_din_ready",  int'(din_ready), 1);
    chk("midrst_dout_re1",   int'(dout_re[1]), 0);
    chk("midrst_fifo_pops",  fifo_rd, fifo_wr);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    push_vec(16'd7500, 3, 0);
    push_vec(16'd7500, 3, 1);
    send_frame(16'd7500);
    idle();
    wait_out("post_rst_b0");
    chk("post_rst_b0_last", int'(dout_last), 0);
    chk("post_rst_b0_re0",  int'(dout_re[0]), 7531);
    @(posedge clk);
    #1;
    chk("post_rst_b1_last", int'(dout_last), 1);
    chk("post_rst_b1_re0",  int'(dout_re[0]), 7515);
    drain("final");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
- Streaming reorder stage directly downstream of the bit-reversal index FIFO; consumes its 16-lane index vectors to put FFT output samples back in natural order.
- Accepts a 32-point frame of complex samples as two 16-lane beats into a ping-pong buffer.
- Pops one index vector per output beat from the FIFO and gathers each output lane from the buffered frame.
- Emits the reordered frame as two 16-lane beats.

Parameters:
- N_PTS, 32, points per frame and buffer depth per bank; index width is log2(N_PTS).
- LANES, 16, samples per beat; N_PTS = 2*LANES.
- IDX_W, 5, index width; must match the FIFO WIDTH.
- DW, 16, bits per real or imag component (two's complement, passed through unchanged).

Ports:
- clk, in, 1: clock; all state updates on posedge.
- rstn, in, 1: asynchronous active-low reset.
- din_valid, in, 1: input beat valid.
- din_ready, out, 1: input beat accepted when din_valid && din_ready.
- din_re, in, [DW-1:0] x [0:LANES-1]: real parts of the input beat.
- din_im, in, [DW-1:0] x [0:LANES-1]: imaginary parts of the input beat.
- idx_empty, in, 1: index FIFO empty flag.
- idx_req, out, 1: drives the FIFO dout_en; one pop per asserted cycle.
- idx_in, in, [IDX_W-1:0] x [0:LANES-1]: FIFO out_index; valid the cycle after idx_req.
- dout_valid, out, 1: output beat valid; no backpressure.
- dout_last, out, 1: marks the second beat of an output frame.
- dout_re, out, [DW-1:0] x [0:LANES-1]: real parts of the output beat.
- dout_im, out, [DW-1:0] x [0:LANES-1]: imaginary parts of the output beat.

Behaviour:
- Reset (async, rstn=0):
  - dout_valid=0, dout_last=0, dout_re/dout_im=0.
  - bank_full[1:0]=0, wr_bank=0, wr_beat=0, rd_bank=0, idx_pend=0, rd state R_IDLE.
  - Buffer contents are not reset. Any in-flight frame is discarded, and idx_req is 0 while rstn=0.
- Write side:
  - din_ready = !bank_full[wr_bank], combinational.
  - Accepted beat with wr_beat=0 writes bank[wr_bank][0..15]; with wr_beat=1 it writes bank[wr_bank][16..31].
  - wr_beat toggles on each accepted beat.
  - On an accepted beat1: bank_full[wr_bank]<=1 and wr_bank toggles.
  - din_valid while din_ready=0 is ignored: no write, no beat advance.
- Read FSM (R_IDLE, R_B1):
  - idx_req is combinational. R_IDLE: idx_req = bank_full[rd_bank] && !idx_empty. R_B1: idx_req = !idx_empty.
  - R_IDLE with idx_req: go to R_B1; register pend_beat=0 and pend_bank=rd_bank.
  - R_B1 with idx_req: go to R_IDLE; register pend_beat=1 and pend_bank=rd_bank; rd_bank toggles.
  - R_B1 with idx_empty=1: stay in R_B1 and wait; the gap is permitted.
  - idx_pend <= idx_req each cycle.
- Gather, in any cycle with idx_pend=1:
  - dout_re[i] <= bank[pend_bank][idx_in[i]].re for i = 0..LANES-1; same for dout_im.
  - dout_valid<=1 and dout_last<=pend_beat.
  - If pend_beat=1, bank_full[pend_bank]<=0. If a write sets a different bank full on the same edge, both updates apply.
  - Otherwise dout_valid<=0 and dout_last<=0; dout data holds its last value.
- Latency: dout_valid asserts 2 cycles after the idx_req cycle.
- Throughput: one frame per 2 cycles sustained, with back-to-back frames and no bubble when both banks and the FIFO keep up.
- Hazards:
  - A bank is freed on the gather edge of its beat1; the earliest overwrite is the following cycle, so no read/write collision.
  - Duplicate indices in a vector are legal; lanes receive the same sample.
- Boundaries:
  - Both banks full: din_ready=0 until beat1 of rd_bank is gathered.
  - FIFO empty at frame start: no request, bank stays full.

Test Plan:
- Single frame: beat0 samples re=0..15, beat1 re=16..31 (im = re+100); FIFO vectors bitrev5(0..15) then bitrev5(16..31) -> dout beat0 re = {0,16,8,24,...}, beat1 re = {1,17,9,...}; dout_last=0 then 1; dout_valid 2 cycles after each idx_req.
- Continuous streaming: 8 frames back-to-back with FIFO never empty -> din_ready stays 1, dout_valid high every cycle after the initial latency, 16 output beats in order.
- Index starvation: frame buffered, idx_empty=1 for 5 cycles after the beat0 pop -> FSM holds in R_B1, idx_req=0, beat1 output appears 2 cycles after idx_empty drops.
- Backpressure: 3 frames sent with idx_empty=1 throughout -> din_ready=0 after frame 2 beat1; frame 3 beat0 is held by the source and accepted one cycle after frame 1 beat1 is gathered.
- Reset mid-frame: assert rstn=0 after beat0 output -> dout_valid=0, idx_req=0 immediately; after release, the next frame outputs correctly from bank 0.
- Identity/duplicate indices: vector all 7 -> all 16 lanes equal sample 7.
